// File: rtl/adder_pkg.sv
// Shared constants for the sequential chunked adder: FSM encoding and default sizing.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/ready/done handshake and operand/result bus of the sequential chunked adder.
interface seq_chunk_adder_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  ready, sum, cout, ovf, done
    );

    modport slave (
        input  start, a, b, cin,
        output ready, sum, cout, ovf, done
    );
endinterface

// File: rtl/ripple_slice.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB for overflow.
module ripple_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // Full-adder chain, one stage per bit
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per clock, carry held between slices.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic               clk,
    input  logic               rst,
    seq_chunk_adder_if.slave   bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned ACC_W  = (CHUNK < WIDTH) ? (WIDTH - CHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             ready_r;
    logic             done_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [ACC_W-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             accept;
    logic             last;

    assign accept = bus.start & ready_r;
    assign last   = (cnt == CNT_W'(NCHUNK - 1));

    ripple_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (a_sh[CHUNK-1:0]),
        .b     (b_sh[CHUNK-1:0]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    // New slice result enters the accumulator from the top; only the upper part is kept between edges
    if (CHUNK < WIDTH) begin : g_multi
        assign acc_next = {slice_sum, acc};
    end else begin : g_single
        assign acc_next = slice_sum;
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last)      state_next = ST_DONE;
            ST_DONE: state_next = bus.start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, with ready/done registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_r <= (state_next != ST_RUN);
            done_r  <= (state_next == ST_DONE);
        end
    end

    // Operand capture, per-slice shifting/accumulation and result update on the final slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            acc   <= '0;
        end else if (state == ST_RUN) begin
            a_sh  <= a_sh >> CHUNK;
            b_sh  <= b_sh >> CHUNK;
            acc   <= ACC_W'(acc_next >> CHUNK);
            carry <= slice_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum_r  <= acc_next;
                cout_r <= slice_cout;
                ovf_r  <= slice_cmsb ^ slice_cout;
            end
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.sum   = sum_r;
    assign bus.cout  = cout_r;
    assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder in three configurations (16/4, 4/1, 16/16).
module tb_seq_chunk_adder;

    typedef struct {
        int          dut;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_chunk_adder_if #(.WIDTH(16)) if0 ();
    seq_chunk_adder_if #(.WIDTH(4))  if1 ();
    seq_chunk_adder_if #(.WIDTH(16)) if2 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    seq_chunk_adder #(.WIDTH(4),  .CHUNK(1))  u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int wid [3] = '{16, 4, 16};
    int nch [3] = '{4, 4, 1};

    logic        st [3];
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        ci [3];
    logic [15:0] sm [3];
    logic        co [3];
    logic        ov [3];
    logic        rd [3];
    logic        dn [3];

    assign if0.start = st[0]; assign if0.a = av[0];      assign if0.b = bv[0];      assign if0.cin = ci[0];
    assign if1.start = st[1]; assign if1.a = av[1][3:0]; assign if1.b = bv[1][3:0]; assign if1.cin = ci[1];
    assign if2.start = st[2]; assign if2.a = av[2];      assign if2.b = bv[2];      assign if2.cin = ci[2];

    assign sm[0] = if0.sum;            assign co[0] = if0.cout; assign ov[0] = if0.ovf;
    assign sm[1] = {12'h000, if1.sum}; assign co[1] = if1.cout; assign ov[1] = if1.ovf;
    assign sm[2] = if2.sum;            assign co[2] = if2.cout; assign ov[2] = if2.ovf;
    assign rd[0] = if0.ready; assign rd[1] = if1.ready; assign rd[2] = if2.ready;
    assign dn[0] = if0.done;  assign dn[1] = if1.done;  assign dn[2] = if2.done;

    exp_t        q[$];
    logic [15:0] last_sum  [3] = '{16'h0, 16'h0, 16'h0};
    logic        last_cout [3] = '{1'b0, 1'b0, 1'b0};
    logic        last_ovf  [3] = '{1'b0, 1'b0, 1'b0};
    int          done_cyc  [3] = '{0, 0, 0};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: full-width add, overflow from operand/result sign bits
    function automatic exp_t model(input int d, input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t        e;
        int          w;
        logic [16:0] mask;
        logic [16:0] full;
        w    = wid[d];
        mask = (17'd1 << w) - 17'd1;
        full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'h0, cin};
        e.dut  = d;
        e.sum  = 16'(full & mask);
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.due  = 0;
        return e;
    endfunction

    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t e;
        int   n = 0;
        while (!rd[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rd[d]) check_val("ready_timeout", 32'(rd[d]), 32'd1);
        st[d] = 1'b1; av[d] = a; bv[d] = b; ci[d] = cin;
        @(posedge clk);
        #1;
        st[d] = 1'b0;
        e     = model(d, a, b, cin);
        e.due = cyc + nch[d];
        q.push_back(e);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        @(negedge clk);
        while (!dn[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!dn[d]) check_val("done_timeout", 32'(dn[d]), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_val("drain", 32'(q.size()), 32'd0);
    endtask

    // Monitor: score each done pulse, otherwise results must hold their last completed value
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (dn[d]) begin
                    if (q.size() == 0) begin
                        check_val("unexpected_done", 32'(d), 32'hFFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check_val("dut_order", 32'(d), 32'(e.dut));
                        check_val("sum", 32'(sm[d]), 32'(e.sum));
                        check_val("cout", 32'(co[d]), 32'(e.cout));
                        check_val("ovf", 32'(ov[d]), 32'(e.ovf));
                        check_val("latency", 32'(cyc), 32'(e.due));
                        last_sum[d]  = e.sum;
                        last_cout[d] = e.cout;
                        last_ovf[d]  = e.ovf;
                        done_cyc[d]  = cyc;
                    end
                end else begin
                    check_val("hold", {14'h0, ov[d], co[d], sm[d]},
                              {14'h0, last_ovf[d], last_cout[d], last_sum[d]});
                end
            end
        end
    end

    initial begin
        int t;
        for (int d = 0; d < 3; d++) begin
            st[d] = 1'b0; av[d] = '0; bv[d] = '0; ci[d] = 1'b0;
        end

        // Reset values
        #12;
        for (int d = 0; d < 3; d++) begin
            check_val("rst_ready", 32'(rd[d]), 32'd1);
            check_val("rst_done", 32'(dn[d]), 32'd0);
            check_val("rst_out", {15'h0, ov[d], co[d], sm[d]}, 32'd0);
        end
        @(negedge clk); #2; rst = 1'b0;

        // 16-bit / 4-bit slices
        op(0, 16'h1234, 16'h4321, 1'b0);
        drain();
        op(0, 16'hFFFF, 16'h0000, 1'b1);
        drain();
        op(0, 16'h7FFF, 16'h0001, 1'b0);
        drain();
        op(0, 16'h8000, 16'h8000, 1'b0);
        drain();

        // start during RUN must be ignored
        op(0, 16'h0F0F, 16'h0101, 1'b1);
        st[0] = 1'b1; av[0] = 16'h1111; bv[0] = 16'h1111; ci[0] = 1'b0;
        check_val("busy_ready", 32'(rd[0]), 32'd0);
        @(posedge clk); #1;
        st[0] = 1'b0;
        drain();

        // Back-to-back: new start in the DONE cycle, no idle gap
        op(0, 16'h1234, 16'h4321, 1'b0);
        wait_done(0);
        t = cyc;
        op(0, 16'hABCD, 16'h1111, 1'b0);
        check_val("b2b_accept", 32'(cyc), 32'(t + 1));
        drain();

        // Reset during RUN abandons the op and clears outputs at once
        op(0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_val("midrst_ready", 32'(rd[0]), 32'd1);
        check_val("midrst_done", 32'(dn[0]), 32'd0);
        check_val("midrst_out", {15'h0, ov[0], co[0], sm[0]}, 32'd0);
        q.delete();
        last_sum[0] = '0; last_cout[0] = 1'b0; last_ovf[0] = 1'b0;
        @(negedge clk); #2; rst = 1'b0;
        repeat (6) @(negedge clk);
        op(0, 16'h00FF, 16'h0001, 1'b0);
        drain();

        // 4-bit / 1-bit slices
        op(1, 16'h000B, 16'h0004, 1'b0);
        drain();
        op(1, 16'h0007, 16'h000D, 1'b1);
        drain();
        op(1, 16'h0007, 16'h0001, 1'b0);
        drain();

        // Single-cycle configuration
        op(2, 16'h1234, 16'h4321, 1'b0);
        drain();
        op(2, 16'h7FFF, 16'h0001, 1'b1);
        wait_done(2);
        op(2, 16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
